fpu_cmd_sequencer: RTL and testbench
====================================

Name: fpu_cmd_sequencer

Overview:
- Upstream/downstream wrapper around the fpu datapath (ports clk, A, B, opcode, O).
- Buffers operand/opcode commands from a producer in a small FIFO and drives the FPU operand bus one command at a time.
- Waits the FPU's fixed latency, captures O, and returns it to a consumer over a valid/ready handshake, together with the opcode and a divide-by-zero flag.
- Lets upstream logic stream FP operations without tracking FPU timing.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- FPU_LATENCY, 1: clock edges from fpu_a/fpu_b/fpu_opcode being stable to fpu_o being valid; range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  command offered
- in_ready  out  1  command FIFO can accept
- in_a  in  32  IEEE-754 single operand A
- in_b  in  32  IEEE-754 single operand B
- in_opcode  in  2  00 add, 01 sub, 10 div, 11 mul
- fpu_a  out  32  to fpu A
- fpu_b  out  32  to fpu B
- fpu_opcode  out  2  to fpu opcode
- fpu_o  in  32  from fpu O
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  32  captured fpu_o
- out_opcode  out  2  opcode of the returned result
- out_divz  out  1  result came from a divide with B[30:0]==0 (±0)

Behaviour:
- Reset: sampled on the rising edge while rst_n=0.
  - FIFO emptied; state IDLE.
  - fpu_a, fpu_b, fpu_opcode, out_result, out_opcode, out_divz = 0; out_valid = 0.
  - in_ready forced 0 combinationally while rst_n=0; pushes during reset are discarded.
  - Reset mid-operation abandons the in-flight command; no result is emitted for it.
- FIFO:
  - push = in_valid & in_ready; in_ready = rst_n & (count != DEPTH).
  - No push→pop bypass: a command pushed at edge t can be popped at edge t+1 at the earliest.
  - Push and pop in the same cycle leave the count unchanged.
  - Read/write pointers wrap modulo DEPTH; count width is clog2(DEPTH+1).
- FSM, states IDLE, EXEC, RESP:
  - IDLE:
    - If FIFO is non-empty: pop; register the head into fpu_a/fpu_b/fpu_opcode; latch divz = (opcode==10) & (B[30:0]==0); load wait counter with FPU_LATENCY; go EXEC.
    - Otherwise stay in IDLE.
  - EXEC:
    - If counter != 0: decrement.
    - If counter == 0: capture fpu_o into out_result, opcode into out_opcode, divz into out_divz; set out_valid=1; go RESP.
    - EXEC therefore lasts FPU_LATENCY+1 cycles.
  - RESP:
    - Hold out_valid and keep out_result, out_opcode and out_divz stable until out_ready=1.
    - On the edge with out_valid & out_ready: clear out_valid; go IDLE.
    - No pop occurs in this cycle.
- fpu_a/fpu_b/fpu_opcode hold the last issued command until the next pop; they are not cleared after use.
- Latency, with out_ready held at 1:
  - Push edge t → pop edge t+1 → capture edge t+FPU_LATENCY+2.
  - out_valid is high in the cycle following that edge.
- Throughput: one command per FPU_LATENCY+3 cycles.
- Capacity: DEPTH queued commands plus 1 in the FSM.
- Results are returned strictly in push order; no command is dropped or duplicated.

Decomposition:
- Shared package fpu_pkg:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_DIV=2'b10, OP_MUL=2'b11;
  - FSM state encoding;
  - command struct width (66 bits = a, b, opcode).
- Sub-module fpu_cmd_fifo (parameter DEPTH; push/pop/full/empty/head) holds the FIFO.
- The FSM, wait counter and output registers live in fpu_cmd_sequencer.

Test Plan:
- Bench conventions: FPU_LATENCY=1 and DEPTH=4 unless stated; the bench models the FPU by driving fpu_o as a function of fpu_* delayed FPU_LATENCY edges.
- Reset: rst_n=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, all fpu_*/out_* = 0; after release, nothing emerges.
- Single add: push A=0x40F00000 (7.5), B=0x40500000 (3.25), op=00 at edge 0; model returns 0x412C0000 → fpu_a=0x40F00000 after edge 1, out_valid=1 after edge 3 with out_result=0x412C0000, out_opcode=00, out_divz=0.
- Fill/backpressure: out_ready=0, in_valid=1 continuously with 6 distinct commands → exactly 5 accepted and then in_ready stays 0. Over 10 cycles, out_valid/out_result remain constant. Raising out_ready drains all 5 in push order, and in_ready reasserts after the first pop.
- Div-by-zero: op=10, B=0x80000000 → out_divz=1. op=10, B=0x40400000 → out_divz=0. op=11, B=0x00000000 → out_divz=0.
- Latency sweep: FPU_LATENCY=3, push at edge 0 → capture at edge 5, and the result equals the model output for the issued operands, not stale data.
- Reset mid-operation: pulse rst_n=0 for one cycle while in EXEC with 2 commands queued → state IDLE, FIFO empty, out_valid never asserts for the abandoned commands, and a new push afterwards completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command sequencer: opcodes, command layout
// and FSM state encoding.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam int CMD_W = 66;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  opcode;
    } fpu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } seq_state_t;

    // Sign bit is ignored so that both +0 and -0 divisors are flagged.
    function automatic logic is_div_by_zero(input fpu_cmd_t cmd);
        return (cmd.opcode == OP_DIV) && (cmd.b[30:0] == 31'd0);
    endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO between the producer and the sequencer FSM; no push-to-pop
// bypass, so a command is visible at the head one cycle after it is written.
module fpu_cmd_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  fpu_cmd_t wr_cmd,
    output logic     full,
    output logic     empty,
    output fpu_cmd_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fpu_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign head  = mem[rd_ptr];

    // Storage carries no reset so it can map onto plain register files.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_cmd;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Feeds queued commands to a fixed-latency FPU one at a time and returns
// each captured result over a valid/ready handshake in issue order.
module fpu_cmd_sequencer
    import fpu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int FPU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_opcode,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_opcode,
    input  logic [31:0] fpu_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [1:0]  out_opcode,
    output logic        out_divz
);

    seq_state_t state;
    seq_state_t state_next;
    fpu_cmd_t   in_cmd;
    fpu_cmd_t   head;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] wait_cnt;
    logic       divz_q;

    assign in_cmd   = '{a: in_a, b: in_b, opcode: in_opcode};
    assign in_ready = rst_n & ~fifo_full;
    assign push     = in_valid & in_ready;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wr_cmd (in_cmd),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (wait_cnt == 4'd0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The FPU operand bus keeps the last issued command until the next pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_opcode <= '0;
            divz_q     <= 1'b0;
            wait_cnt   <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_opcode <= '0;
            out_divz   <= 1'b0;
        end else begin
            if (pop) begin
                fpu_a      <= head.a;
                fpu_b      <= head.b;
                fpu_opcode <= head.opcode;
                divz_q     <= is_div_by_zero(head);
                wait_cnt   <= 4'(FPU_LATENCY);
            end
            if (state == ST_EXEC) begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt <= wait_cnt - 4'd1;
                end else begin
                    out_result <= fpu_o;
                    out_opcode <= fpu_opcode;
                    out_divz   <= divz_q;
                    out_valid  <= 1'b1;
                end
            end
            if ((state == ST_RESP) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Scoreboard bench for fpu_cmd_sequencer: a latency-1 and a latency-3
// instance, each fed by a table-driven FPU model.
module tb_fpu_cmd_sequencer;
    import fpu_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic        divz;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  op;
        logic        divz;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_divz;
    logic [31:0] in_a, in_b, fpu_a, fpu_b, fpu_o, out_result;
    logic [1:0]  in_opcode, fpu_opcode, out_opcode;

    logic        l3_in_valid, l3_in_ready, l3_out_valid, l3_out_ready, l3_out_divz;
    logic [31:0] l3_in_a, l3_in_b, l3_fpu_a, l3_fpu_b, l3_fpu_o, l3_out_result;
    logic [1:0]  l3_in_opcode, l3_fpu_opcode, l3_out_opcode;
    logic [31:0] l3_pipe0, l3_pipe1, l3_pipe2;

    exp_t exp_q[$];
    exp_t l3_q[$];

    fpu_cmd_sequencer #(.DEPTH(4), .FPU_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_opcode(out_opcode), .out_divz(out_divz)
    );

    fpu_cmd_sequencer #(.DEPTH(4), .FPU_LATENCY(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .in_valid(l3_in_valid), .in_ready(l3_in_ready),
        .in_a(l3_in_a), .in_b(l3_in_b), .in_opcode(l3_in_opcode),
        .fpu_a(l3_fpu_a), .fpu_b(l3_fpu_b), .fpu_opcode(l3_fpu_opcode), .fpu_o(l3_fpu_o),
        .out_valid(l3_out_valid), .out_ready(l3_out_ready), .out_result(l3_out_result),
        .out_opcode(l3_out_opcode), .out_divz(l3_out_divz)
    );

    // Hand-computed IEEE-754 single vectors: a, b, opcode, result, divz.
    function automatic vec_t vec_at(input int idx);
        case (idx)
            0:  return {32'h40F00000, 32'h40500000, OP_ADD, 32'h412C0000, 1'b0};
            1:  return {32'h40F00000, 32'h40500000, OP_SUB, 32'h40880000, 1'b0};
            2:  return {32'h40000000, 32'h40400000, OP_MUL, 32'h40C00000, 1'b0};
            3:  return {32'h40C00000, 32'h40400000, OP_DIV, 32'h40000000, 1'b0};
            4:  return {32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 1'b0};
            5:  return {32'h40A00000, 32'h3F800000, OP_SUB, 32'h40800000, 1'b0};
            6:  return {32'h3FC00000, 32'h3FC00000, OP_MUL, 32'h40100000, 1'b0};
            7:  return {32'h3F800000, 32'h40800000, OP_DIV, 32'h3E800000, 1'b0};
            8:  return {32'h3F800000, 32'h80000000, OP_DIV, 32'hFF800000, 1'b1};
            9:  return {32'h41400000, 32'h40400000, OP_DIV, 32'h40800000, 1'b0};
            10: return {32'h40400000, 32'h00000000, OP_MUL, 32'h00000000, 1'b0};
            default: return {32'h3F800000, 32'h00000000, OP_DIV, 32'h7F800000, 1'b1};
        endcase
    endfunction

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        vec_t v;
        for (int i = 0; i < 12; i++) begin
            v = vec_at(i);
            if (v.a == a && v.b == b && v.op == op) return v.res;
        end
        return 32'hDEADBEEF;
    endfunction

    // FPU models: the result appears FPU_LATENCY edges after the operands.
    always @(posedge clk) fpu_o <= fpu_model(fpu_a, fpu_b, fpu_opcode);

    always @(posedge clk) begin
        l3_pipe0 <= fpu_model(l3_fpu_a, l3_fpu_b, l3_fpu_opcode);
        l3_pipe1 <= l3_pipe0;
        l3_pipe2 <= l3_pipe1;
    end
    assign l3_fpu_o = l3_pipe2;

    always @(negedge clk) begin : monitor_l1
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL l1_unexpected: got result=%h op=%b divz=%b, required no output",
                         out_result, out_opcode, out_divz);
            end else begin
                e = exp_q.pop_front();
                if ({out_result, out_opcode, out_divz} !== e) begin
                    errors++;
                    $display("[TB] FAIL l1_result: got result=%h op=%b divz=%b, required result=%h op=%b divz=%b",
                             out_result, out_opcode, out_divz, e.res, e.op, e.divz);
                end
            end
        end
    end

    always @(negedge clk) begin : monitor_l3
        exp_t e;
        if (rst_n && l3_out_valid && l3_out_ready) begin
            checks++;
            if (l3_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL l3_unexpected: got result=%h, required no output", l3_out_result);
            end else begin
                e = l3_q.pop_front();
                if ({l3_out_result, l3_out_opcode, l3_out_divz} !== e) begin
                    errors++;
                    $display("[TB] FAIL l3_result: got result=%h op=%b divz=%b, required result=%h op=%b divz=%b",
                             l3_out_result, l3_out_opcode, l3_out_divz, e.res, e.op, e.divz);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Offers one table vector (starting at a negedge) and returns at the negedge after it is accepted.
    task automatic applyStimulus(input int idx, input bit to_l3);
        vec_t v;
        bit   done;
        v    = vec_at(idx);
        done = 1'b0;
        for (int w = 0; w < 20 && !done; w++) begin
            if (to_l3) begin
                l3_in_valid = 1'b1; l3_in_a = v.a; l3_in_b = v.b; l3_in_opcode = v.op;
                if (l3_in_ready) begin
                    l3_q.push_back({v.res, v.op, v.divz});
                    done = 1'b1;
                end
            end else begin
                in_valid = 1'b1; in_a = v.a; in_b = v.b; in_opcode = v.op;
                if (in_ready) begin
                    exp_q.push_back({v.res, v.op, v.divz});
                    done = 1'b1;
                end
            end
            @(negedge clk);
        end
        in_valid    = 1'b0;
        l3_in_valid = 1'b0;
        checkOutput("push_accepted", {31'd0, done}, 32'd1);
    endtask

    task automatic waitDrain(input bit to_l3);
        bit drained;
        drained = 1'b0;
        for (int w = 0; w < 80 && !drained; w++) begin
            @(negedge clk);
            #1;
            if (to_l3) drained = (l3_q.size() == 0) && !l3_out_valid;
            else       drained = (exp_q.size() == 0) && !out_valid;
        end
        checkOutput("drain_done", {31'd0, drained}, 32'd1);
    endtask

    int          accepted;
    bit          saw_flag;
    bit          changed;
    logic [31:0] held_result;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; l3_out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'h40F00000; in_b = 32'h40500000; in_opcode = OP_ADD;
        l3_in_valid = 1'b0; l3_in_a = '0; l3_in_b = '0; l3_in_opcode = '0;

        // Reset held for three edges with a command offered.
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_fpu_a", fpu_a, 32'd0);
        checkOutput("rst_fpu_b", fpu_b, 32'd0);
        checkOutput("rst_fpu_opcode", {30'd0, fpu_opcode}, 32'd0);
        checkOutput("rst_out_fields", out_result | {30'd0, out_opcode} | {31'd0, out_divz}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        saw_flag = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) saw_flag = 1'b1;
        end
        checkOutput("post_rst_no_output", {31'd0, saw_flag}, 32'd0);
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single add with exact cycle timing.
        applyStimulus(0, 1'b0);
        checkOutput("add_valid_e0", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("add_fpu_a_e1", fpu_a, 32'h40F00000);
        checkOutput("add_fpu_b_e1", fpu_b, 32'h40500000);
        @(negedge clk);
        checkOutput("add_valid_e2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("add_valid_e3", {31'd0, out_valid}, 32'd1);
        checkOutput("add_result_e3", out_result, 32'h412C0000);
        waitDrain(1'b0);

        // Fill with the consumer stalled.
        out_ready = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_a = vec_at(1 + accepted).a; in_b = vec_at(1 + accepted).b;
            in_opcode = vec_at(1 + accepted).op;
            if (in_ready) begin
                exp_q.push_back({vec_at(1 + accepted).res, vec_at(1 + accepted).op,
                                 vec_at(1 + accepted).divz});
                accepted++;
            end
            @(negedge clk);
        end
        checkOutput("fill_accepted", accepted, 32'd5);
        held_result = out_result;
        saw_flag = 1'b0;
        changed  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready) saw_flag = 1'b1;
            if (out_valid !== 1'b1 || out_result !== held_result) changed = 1'b1;
        end
        checkOutput("fill_in_ready_low", {31'd0, saw_flag}, 32'd0);
        checkOutput("fill_output_stable", {31'd0, changed}, 32'd0);
        checkOutput("fill_held_result", held_result, 32'h40880000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        saw_flag  = 1'b0;
        for (int w = 0; w < 5 && !saw_flag; w++) begin
            @(negedge clk);
            if (in_ready) saw_flag = 1'b1;
        end
        checkOutput("fill_in_ready_back", {31'd0, saw_flag}, 32'd1);
        waitDrain(1'b0);

        // Divide-by-zero flag: -0, nonzero, mul by zero, +0.
        applyStimulus(8, 1'b0);
        applyStimulus(9, 1'b0);
        applyStimulus(10, 1'b0);
        applyStimulus(11, 1'b0);
        waitDrain(1'b0);

        // Latency-3 instance: push edge 0, capture edge 5.
        applyStimulus(7, 1'b1);
        saw_flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (l3_out_valid) saw_flag = 1'b1;
        end
        checkOutput("l3_early_valid", {31'd0, saw_flag}, 32'd0);
        @(negedge clk);
        checkOutput("l3_valid_e5", {31'd0, l3_out_valid}, 32'd1);
        waitDrain(1'b1);
        applyStimulus(2, 1'b1);
        waitDrain(1'b1);

        // Reset pulse while the first of three commands is executing.
        applyStimulus(3, 1'b0);
        applyStimulus(4, 1'b0);
        applyStimulus(5, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_in_ready_back", {31'd0, in_ready}, 32'd1);
        saw_flag = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) saw_flag = 1'b1;
        end
        checkOutput("midrst_no_output", {31'd0, saw_flag}, 32'd0);
        applyStimulus(6, 1'b0);
        waitDrain(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
